// File: rtl/fir_out_decim.sv
// FIR output stage: decimate by DECIM, round/saturate 18->16 bits, buffer in a FWFT FIFO.
// Optional saturation event counter o_sat_cnt when SAT_STATS_EN is defined.
module fir_out_decim #(
  parameter int DECIM      = 4,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic signed [17:0] i_y,
  input  logic               i_valid,
  output logic signed [15:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_full,
  output logic               o_ovf
`ifdef SAT_STATS_EN
  ,
  output logic [15:0]        o_sat_cnt
`endif
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [18:0] RND = 19'sd1 <<< (SHIFT - 1);

  typedef struct packed {
    logic               push;
    logic signed [15:0] data;
  } stage_t;

  logic [PW-1:0] phase;
  logic          keep;

  assign keep = i_valid && (phase == '0);

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst)
      phase <= '0;
    else if (i_valid)
      phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
  end

  // 19-bit arithmetic so the rounding add cannot wrap at the positive rail
  logic signed [18:0] y_ext, sum, t;
  logic signed [15:0] q;
  logic               sat;

  always_comb begin
    y_ext = {i_y[17], i_y};
    sum   = y_ext + RND;
    t     = sum >>> SHIFT;
    q     = t[15:0];
    sat   = 1'b0;
    if (t > 19'sd32767) begin
      q   = 16'sh7FFF;
      sat = 1'b1;
    end else if (t < -19'sd32768) begin
      q   = 16'sh8000;
      sat = 1'b1;
    end
  end

  stage_t s1;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      s1 <= '0;
    end else begin
      s1.push <= keep;
      if (keep) s1.data <= q;
    end
  end

`ifdef SAT_STATS_EN
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst)
      o_sat_cnt <= '0;
    else if (keep && sat && (o_sat_cnt != 16'hFFFF))
      o_sat_cnt <= o_sat_cnt + 16'd1;
  end
`endif

  logic signed [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr, rd_next;
  logic [AW:0]        count, count_vis;
  logic               full, pop, wr_en, drop;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = o_valid && i_ready;
  assign wr_en     = s1.push && (!full || pop);
  assign drop      = s1.push && full && !pop;
  assign rd_next   = rd_ptr + AW'(pop);
  // entries already resident before this edge; a same-edge push shows up one cycle later
  assign count_vis = count - {{AW{1'b0}}, pop};
  assign o_full    = full;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s1.data;
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      o_valid <= (count_vis != '0);
      if (count_vis != '0) o_data <= mem[rd_next];
      if (drop) o_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_out_decim.sv
// Bench for fir_out_decim: a DECIM=1 and a DECIM=4 instance, queue scoreboards on the
// output handshake, a vector table for rounding/saturation and hand sequences for the rest.
module tb_fir_out_decim;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic signed [17:0] y1, y4;
  logic               v1, v4, rdy1, rdy4;
  logic signed [15:0] d1, d4;
  logic               ov1, ov4, full1, full4, ovf1, ovf4;
  logic [15:0]        sat1, sat4;

  fir_out_decim #(.DECIM(1), .SHIFT(2), .FIFO_DEPTH(8)) u1 (
    .clk(clk), .i_rst(rst_n), .i_y(y1), .i_valid(v1), .o_data(d1), .o_valid(ov1),
    .i_ready(rdy1), .o_full(full1), .o_ovf(ovf1)
`ifdef SAT_STATS_EN
    , .o_sat_cnt(sat1)
`endif
  );

  fir_out_decim #(.DECIM(4), .SHIFT(2), .FIFO_DEPTH(8)) u4 (
    .clk(clk), .i_rst(rst_n), .i_y(y4), .i_valid(v4), .o_data(d4), .o_valid(ov4),
    .i_ready(rdy4), .o_full(full4), .o_ovf(ovf4)
`ifdef SAT_STATS_EN
    , .o_sat_cnt(sat4)
`endif
  );

`ifndef SAT_STATS_EN
  assign sat1 = '0;
  assign sat4 = '0;
`endif

  int checks = 0;
  int errors = 0;
  logic signed [15:0] q1[$];
  logic signed [15:0] q4[$];
  logic signed [15:0] e1, e4;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // outputs are accepted at the next posedge when o_valid & i_ready at this negedge
  always @(negedge clk) begin
    if (rst_n && ov1 && rdy1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL u1_unexpected got %0d expected none", d1);
      end else begin
        e1 = q1.pop_front();
        if (d1 !== e1) begin
          errors++;
          $display("FAIL u1_data got %0d expected %0d", d1, e1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov4 && rdy4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL u4_unexpected got %0d expected none", d4);
      end else begin
        e4 = q4.pop_front();
        if (d4 !== e4) begin
          errors++;
          $display("FAIL u4_data got %0d expected %0d", d4, e4);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input int y, input bit kept, input int exp);
    v1 = 1'b1;
    y1 = 18'(y);
    if (kept) q1.push_back(16'(exp));
    tick();
    v1 = 1'b0;
  endtask

  task automatic drain(input int which);
    for (int i = 0; i < 60; i++) begin
      if ((which == 1 ? q1.size() : q4.size()) == 0) break;
      tick();
    end
    repeat (3) tick();
    chk(which == 1 ? "drain_u1" : "drain_u4", which == 1 ? q1.size() : q4.size(), 0);
  endtask

  typedef struct {
    int y;
    int exp;
    bit sat;
  } vec_t;

  vec_t tbl[12];
  int   exp_sat;

  initial begin
    tbl[0]  = '{400, 100, 1'b0};
    tbl[1]  = '{6, 2, 1'b0};
    tbl[2]  = '{-6, -1, 1'b0};
    tbl[3]  = '{5, 1, 1'b0};
    tbl[4]  = '{2, 1, 1'b0};
    tbl[5]  = '{1, 0, 1'b0};
    tbl[6]  = '{-2, 0, 1'b0};
    tbl[7]  = '{-3, -1, 1'b0};
    tbl[8]  = '{131071, 32767, 1'b1};
    tbl[9]  = '{-131072, -32768, 1'b0};
    tbl[10] = '{131070, 32767, 1'b1};
    tbl[11] = '{-131071, -32768, 1'b0};

    rst_n = 1'b0;
    v1 = 0; v4 = 0; y1 = '0; y4 = '0; rdy1 = 0; rdy4 = 0;
    repeat (3) tick();
    chk("rst_valid", int'(ov1), 0);
    chk("rst_full", int'(full1), 0);
    chk("rst_ovf", int'(ovf1), 0);
    chk("rst_data", int'(d1), 0);
    chk("rst_valid4", int'(ov4), 0);
    rst_n = 1'b1;
    tick();

    // latency from empty: captured at edge n, pushed n+1, visible after n+2
    rdy1 = 1'b1;
    send1(400, 1'b1, 100);
    chk("lat_n", int'(ov1), 0);
    tick();
    chk("lat_n1", int'(ov1), 0);
    tick();
    chk("lat_n2_valid", int'(ov1), 1);
    chk("lat_n2_data", int'(d1), 100);
    drain(1);

    exp_sat = 0;
    for (int i = 0; i < 12; i++) begin
      send1(tbl[i].y, 1'b1, tbl[i].exp);
      exp_sat += int'(tbl[i].sat);
    end
    drain(1);
`ifdef SAT_STATS_EN
    chk("sat_cnt", int'(sat1), exp_sat);
`endif

    // decimation: ramp with every third cycle idle, only phase-0 samples come out
    rdy4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v4 = 1'b1;
      y4 = 18'(4 * i);
      if (i % 4 == 0) q4.push_back(16'((4 * i + 2) >>> 2));
      tick();
      v4 = 1'b0;
      if (i % 2 == 1) tick();
    end
    drain(4);

    // backpressure: the 9th and 10th samples find the FIFO full and are dropped
    rdy1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      send1(4 * k, k <= 8, k);
      if (k >= 8) chk($sformatf("bp_full_k%0d", k), int'(full1), int'(k - 1 >= 8));
      if (k >= 9) chk($sformatf("bp_ovf_k%0d", k), int'(ovf1), int'(k == 10));
    end
    tick();
    chk("bp_head_valid", int'(ov1), 1);
    chk("bp_head_data", int'(d1), 1);
    rdy1 = 1'b1;
    drain(1);
    chk("bp_ovf_sticky", int'(ovf1), 1);
    chk("bp_empty_full", int'(full1), 0);

    // full FIFO: a push landing on the same edge as a pop is accepted
    rdy1 = 1'b0;
    for (int k = 11; k <= 18; k++) send1(4 * k, 1'b1, k);
    tick();
    chk("fp_full", int'(full1), 1);
    send1(4 * 19, 1'b1, 19);
    rdy1 = 1'b1;
    chk("fp_full_pre", int'(full1), 1);
    tick();
    rdy1 = 1'b0;
    chk("fp_full_post", int'(full1), 1);
    chk("fp_ovf", int'(ovf1), 1);
    chk("fp_head", int'(d1), 12);
    rdy1 = 1'b1;
    drain(1);

    // asynchronous reset mid-stream with 3 entries queued and u4 mid-phase
    rdy1 = 1'b0;
    rdy4 = 1'b0;
    for (int k = 21; k <= 23; k++) send1(4 * k, 1'b1, k);
    v4 = 1'b1; y4 = 18'sd100; tick();
    y4 = 18'sd104; tick();
    v4 = 1'b0;
    tick();
    chk("pre_rst_valid", int'(ov1), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(ov1), 0);
    chk("arst_full", int'(full1), 0);
    chk("arst_ovf", int'(ovf1), 0);
    chk("arst_valid4", int'(ov4), 0);
    chk("arst_sat", int'(sat1), 0);
    chk("arst_sat4", int'(sat4), 0);
    q1.delete();
    q4.delete();
    tick();
    rst_n = 1'b1;
    rdy1 = 1'b1;
    rdy4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v4 = 1'b1;
      y4 = 18'(400 + 4 * i);
      if (i % 4 == 0) q4.push_back(16'((400 + 4 * i + 2) >>> 2));
      tick();
      v4 = 1'b0;
    end
    drain(4);
    chk("post_rst_u1_idle", int'(ov1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
